// File: rtl/ad9516_pkg.sv
// ad9516_pkg
//   Shared definitions for the AD9516 power-up configuration sequencer:
//   sequencer state encoding, 24-bit SPI word field positions, default
//   timing constants and a counter-width helper.
package ad9516_pkg;

    typedef enum logic [3:0] {
        IDLE,
        POR_WAIT,
        RD_ROM,
        WAIT_ROM,
        SPI_WAIT,
        NEXT,
        LOCK_WAIT,
        DONE,
        ERR
    } cfg_state_e;

    // AD9516 SPI write word: [23:8] instruction (R/W, W1:W0, A12:A0), [7:0] data
    localparam int INSTR_MSB = 23;
    localparam int INSTR_LSB = 8;
    localparam int DATA_MSB  = 7;

    localparam int DEF_REG_NUM          = 64;
    localparam int DEF_ADDR_W           = 6;
    localparam int DEF_POR_WAIT_CYC     = 1000;
    localparam int DEF_LOCK_TIMEOUT_CYC = 1000000;
    localparam int DEF_RETRY_MAX        = 3;

    // Bits needed to count 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ad9516_cfg_sequencer_rise_edge_pulse.sv
// rise_edge_pulse
//   One-cycle pulse on each rising edge of a signal that is already
//   synchronous to clk.
//   clk       : system clock
//   rst_n     : synchronous reset, active-low
//   sig_in    : level input (synchronous)
//   pulse_out : high for the single cycle where sig_in is 1 and was 0
module rise_edge_pulse
    import ad9516_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic pulse_out
);

    logic sig_d1_d;
    logic sig_d1_q;

    always_comb begin
        sig_d1_d = sig_in;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sig_d1_q <= 1'b0;
        end else begin
            sig_d1_q <= sig_d1_d;
        end
    end

    assign pulse_out = sig_in & ~sig_d1_q;

endmodule

// File: rtl/ad9516_cfg_sequencer.sv
// ad9516_cfg_sequencer
//   Power-up configuration sequencer for the AD9516 clock chip. A rising
//   edge on cfg_start walks REG_NUM entries of an external synchronous ROM
//   and hands each 24-bit word to an SPI master (req/ack). After the last
//   write it waits for PLL lock; on timeout it re-runs the whole table up to
//   RETRY_MAX times before flagging an error.
//   clk, rst_n            : clock, synchronous active-low reset
//   cfg_start             : start request, only its rising edge acts
//   rom_addr / rom_data   : table read port, data valid one cycle after addr
//   spi_req / spi_wdata   : write request, word held stable while req=1
//   spi_ack               : one-cycle transfer-complete pulse
//   pll_lock              : asynchronous LD/STATUS pin
//   cfg_busy/done/err     : run status (done/err sticky until next start)
//   retry_cnt             : lock-timeout retries consumed in this run
//   lock_sync             : synchronized pll_lock (live status)
module ad9516_cfg_sequencer
    import ad9516_pkg::*;
#(
    parameter int REG_NUM          = DEF_REG_NUM,
    parameter int ADDR_W           = DEF_ADDR_W,
    parameter int POR_WAIT_CYC     = DEF_POR_WAIT_CYC,
    parameter int LOCK_TIMEOUT_CYC = DEF_LOCK_TIMEOUT_CYC,
    parameter int RETRY_MAX        = DEF_RETRY_MAX
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [23:0]       rom_data,
    output logic              spi_req,
    output logic [23:0]       spi_wdata,
    input  logic              spi_ack,
    input  logic              pll_lock,
    output logic              cfg_busy,
    output logic              cfg_done,
    output logic              cfg_err,
    output logic [1:0]        retry_cnt,
    output logic              lock_sync
);

    localparam int POR_W = cnt_width(POR_WAIT_CYC);
    localparam int TMO_W = cnt_width(LOCK_TIMEOUT_CYC);

    localparam logic [POR_W-1:0]  POR_LAST  = POR_W'(POR_WAIT_CYC - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(LOCK_TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(REG_NUM - 1);
    localparam logic [1:0]        RETRY_LIM = 2'(RETRY_MAX);

    cfg_state_e        state_d,     state_q;
    logic [ADDR_W-1:0] addr_d,      addr_q;
    logic [POR_W-1:0]  por_cnt_d,   por_cnt_q;
    logic [TMO_W-1:0]  tmo_cnt_d,   tmo_cnt_q;
    logic [1:0]        retry_d,     retry_q;
    logic              spi_req_d,   spi_req_q;
    logic [23:0]       spi_wdata_d, spi_wdata_q;
    logic              busy_d,      busy_q;
    logic              done_d,      done_q;
    logic              err_d,       err_q;
    logic              lock_s1_d,   lock_s1_q;
    logic              lock_s2_d,   lock_s2_q;

    logic start_pls;

    rise_edge_pulse u_start_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .sig_in    (cfg_start),
        .pulse_out (start_pls)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            por_cnt_q   <= '0;
            tmo_cnt_q   <= '0;
            retry_q     <= '0;
            spi_req_q   <= 1'b0;
            spi_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            lock_s1_q   <= 1'b0;
            lock_s2_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            por_cnt_q   <= por_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
            retry_q     <= retry_d;
            spi_req_q   <= spi_req_d;
            spi_wdata_q <= spi_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            lock_s1_q   <= lock_s1_d;
            lock_s2_q   <= lock_s2_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        por_cnt_d   = por_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;
        retry_d     = retry_q;
        spi_req_d   = spi_req_q;
        spi_wdata_d = spi_wdata_q;
        busy_d      = busy_q;
        done_d      = done_q;
        err_d       = err_q;
        lock_s1_d   = pll_lock;
        lock_s2_d   = lock_s1_q;

        case (state_q)
            // Start edges are only honoured when no run is in flight.
            IDLE, DONE, ERR: begin
                if (start_pls) begin
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    retry_d   = '0;
                    busy_d    = 1'b1;
                    por_cnt_d = '0;
                    state_d   = POR_WAIT;
                end
            end

            POR_WAIT: begin
                if (por_cnt_q == POR_LAST) begin
                    addr_d  = '0;
                    state_d = RD_ROM;
                end else begin
                    por_cnt_d = por_cnt_q + 1'b1;
                end
            end

            // rom_addr follows addr_q continuously; this cycle presents it
            // to the ROM, whose registered output is valid in WAIT_ROM.
            RD_ROM: begin
                state_d = WAIT_ROM;
            end

            WAIT_ROM: begin
                spi_wdata_d = {rom_data[INSTR_MSB:INSTR_LSB], rom_data[DATA_MSB:0]};
                spi_req_d   = 1'b1;
                state_d     = SPI_WAIT;
            end

            // No ack timeout: the SPI master is trusted to finish.
            SPI_WAIT: begin
                if (spi_ack) begin
                    spi_req_d = 1'b0;
                    state_d   = NEXT;
                end
            end

            NEXT: begin
                if (addr_q == ADDR_LAST) begin
                    tmo_cnt_d = '0;
                    state_d   = LOCK_WAIT;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = RD_ROM;
                end
            end

            // Lock is tested before the timeout so a coincident lock wins.
            LOCK_WAIT: begin
                if (lock_s2_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    if (retry_q < RETRY_LIM) begin
                        retry_d   = retry_q + 1'b1;
                        por_cnt_d = '0;
                        state_d   = POR_WAIT;
                    end else begin
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ERR;
                    end
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rom_addr  = addr_q;
    assign spi_req   = spi_req_q;
    assign spi_wdata = spi_wdata_q;
    assign cfg_busy  = busy_q;
    assign cfg_done  = done_q;
    assign cfg_err   = err_q;
    assign retry_cnt = retry_q;
    assign lock_sync = lock_s2_q;

endmodule

// File: tb/tb_ad9516_cfg_sequencer.sv
// tb_ad9516_cfg_sequencer
//   Directed scenarios with randomized ROM contents and SPI ack latency.
//   Expected write streams and flags come from a pass-level model: each
//   pass writes ROM[0..REG_NUM-1] in order; the number of passes and the
//   final flags follow from when lock is presented.
module tb_ad9516_cfg_sequencer;

    localparam int REG_N = 4;
    localparam int AW    = 6;
    localparam int POR   = 10;
    localparam int TMO   = 50;
    localparam int RMAX  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cfg_start;
    logic [AW-1:0] rom_addr;
    logic [23:0]   rom_data;
    logic          spi_req;
    logic [23:0]   spi_wdata;
    logic          spi_ack;
    logic          pll_lock;
    logic          cfg_busy;
    logic          cfg_done;
    logic          cfg_err;
    logic [1:0]    retry_cnt;
    logic          lock_sync;

    int checks   = 0;
    int failures = 0;

    logic [23:0] rom [0:63];
    logic [23:0] obs_q [$];
    int          ack_total = 0;
    int          ack_dly   = 5;
    int          ack_cnt   = 0;
    int          unstable  = 0;
    logic        resp_en   = 1'b1;
    logic        resp_ack  = 1'b0;
    logic        force_ack = 1'b0;
    logic        prev_req  = 1'b0;
    logic [23:0] last_w    = '0;

    assign spi_ack = resp_ack | force_ack;

    ad9516_cfg_sequencer #(
        .REG_NUM          (REG_N),
        .ADDR_W           (AW),
        .POR_WAIT_CYC     (POR),
        .LOCK_TIMEOUT_CYC (TMO),
        .RETRY_MAX        (RMAX)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_start (cfg_start),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .spi_req   (spi_req),
        .spi_wdata (spi_wdata),
        .spi_ack   (spi_ack),
        .pll_lock  (pll_lock),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .retry_cnt (retry_cnt),
        .lock_sync (lock_sync)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: one cycle of read latency.
    always @(posedge clk) rom_data <= rom[rom_addr];

    // SPI master model: ack ack_dly negedges after req is seen.
    always @(negedge clk) begin
        resp_ack = 1'b0;
        if (!resp_en || !spi_req) begin
            ack_cnt = 0;
        end else begin
            ack_cnt++;
            if (ack_cnt == ack_dly) begin
                resp_ack = 1'b1;
                ack_cnt  = 0;
                ack_total++;
            end
        end
    end

    // Write monitor: record word on each req rise, flag word changes while held.
    always @(negedge clk) begin
        if (spi_req && !prev_req) obs_q.push_back(spi_wdata);
        if (spi_req && prev_req && spi_wdata !== last_w) unstable++;
        prev_req = spi_req;
        last_w   = spi_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_start();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        int n = 0;
        while (cfg_busy && n < limit) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, {31'd0, cfg_busy}, 32'd0);
    endtask

    task automatic wait_acks(input string tag, input int target, input int limit);
        int n = 0;
        while (ack_total < target && n < limit) begin
            tick();
            n++;
        end
        chk({tag, "_acks"}, (ack_total >= target) ? 32'd1 : 32'd0, 32'd1);
    endtask

    // Model: `passes` full table walks, each ROM[0..REG_N-1] in order.
    task automatic check_writes(input string tag, input int base, input int passes);
        int n = obs_q.size() - base;
        chk({tag, "_nwr"}, n, passes * REG_N);
        for (int i = 0; i < n && i < passes * REG_N; i++)
            chk({tag, "_wd"}, {8'd0, obs_q[base + i]}, {8'd0, rom[i % REG_N]});
    endtask

    task automatic check_flags(input string tag, input logic done, input logic err, input int retries);
        chk({tag, "_done"},  {31'd0, cfg_done}, {31'd0, done});
        chk({tag, "_err"},   {31'd0, cfg_err},  {31'd0, err});
        chk({tag, "_retry"}, {30'd0, retry_cnt}, retries);
        chk({tag, "_busy"},  {31'd0, cfg_busy}, 32'd0);
    endtask

    initial begin
        int base;
        int abase;
        int sz;

        for (int i = 0; i < 64; i++) rom[i] = 24'($urandom);
        rst_n     = 1'b0;
        cfg_start = 1'b0;
        pll_lock  = 1'b0;
        repeat (3) tick();

        // Reset state
        chk("rst_req",   {31'd0, spi_req}, 32'd0);
        chk("rst_wdata", {8'd0, spi_wdata}, 32'd0);
        chk("rst_addr",  {26'd0, rom_addr}, 32'd0);
        check_flags("rst", 1'b0, 1'b0, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // 1: single pass, lock 20 cycles after the last ack
        ack_dly = 5;
        base = obs_q.size(); abase = ack_total;
        do_start();
        chk("t1_busy_on", {31'd0, cfg_busy}, 32'd1);
        wait_acks("t1", abase + REG_N, 500);
        repeat (18) tick();
        pll_lock = 1'b1;
        wait_idle("t1", 300);
        check_writes("t1", base, 1);
        check_flags("t1", 1'b1, 1'b0, 0);
        chk("t1_lsync", {31'd0, lock_sync}, 32'd1);
        pll_lock = 1'b0;
        repeat (4) tick();
        chk("t1_done_sticky", {31'd0, cfg_done}, 32'd1);
        chk("t1_lsync_off",   {31'd0, lock_sync}, 32'd0);

        // 2: long start level plus a second edge while busy -> one pass
        ack_dly = $urandom_range(1, 6);
        base = obs_q.size(); abase = ack_total;
        cfg_start = 1'b1;
        repeat (30) tick();
        chk("t2_busy_hold", {31'd0, cfg_busy}, 32'd1);
        cfg_start = 1'b0;
        tick();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        chk("t2_busy_2nd", {31'd0, cfg_busy}, 32'd1);
        wait_acks("t2", abase + REG_N, 500);
        repeat (5) tick();
        pll_lock = 1'b1;
        wait_idle("t2", 300);
        check_writes("t2", base, 1);
        check_flags("t2", 1'b1, 1'b0, 0);
        pll_lock = 1'b0;
        repeat (3) tick();

        // 3: no lock ever -> RMAX+1 passes then error
        ack_dly = $urandom_range(1, 6);
        base = obs_q.size();
        do_start();
        chk("t3_done_clr", {31'd0, cfg_done}, 32'd0);
        wait_idle("t3", 3000);
        check_writes("t3", base, RMAX + 1);
        check_flags("t3", 1'b0, 1'b1, RMAX);

        // 4: lock on second pass, then restart from DONE
        ack_dly = $urandom_range(1, 6);
        base = obs_q.size(); abase = ack_total;
        do_start();
        chk("t4_err_clr",   {31'd0, cfg_err}, 32'd0);
        chk("t4_retry_clr", {30'd0, retry_cnt}, 32'd0);
        wait_acks("t4", abase + 2 * REG_N, 1500);
        repeat (2) tick();
        pll_lock = 1'b1;
        wait_idle("t4", 300);
        check_writes("t4", base, 2);
        check_flags("t4", 1'b1, 1'b0, 1);
        base = obs_q.size();
        do_start();
        chk("t4r_done_clr", {31'd0, cfg_done}, 32'd0);
        chk("t4r_busy",     {31'd0, cfg_busy}, 32'd1);
        chk("t4r_retry",    {30'd0, retry_cnt}, 32'd0);
        wait_idle("t4r", 500);
        check_writes("t4r", base, 1);
        check_flags("t4r", 1'b1, 1'b0, 0);

        // 6a: lock_sync first high in the final timeout cycle -> lock wins.
        // Last ack is sampled at the edge entering NEXT, LOCK_WAIT starts one
        // edge later, and the synchronizer adds two edges, so presenting lock
        // TMO-1 negedges after the ack lands it on the last timer count.
        pll_lock = 1'b0;
        repeat (3) tick();
        ack_dly = $urandom_range(1, 6);
        base = obs_q.size(); abase = ack_total;
        do_start();
        wait_acks("t6a", abase + REG_N, 500);
        repeat (TMO - 1) tick();
        pll_lock = 1'b1;
        wait_idle("t6a", 500);
        check_writes("t6a", base, 1);
        check_flags("t6a", 1'b1, 1'b0, 0);

        // 6b: one cycle later the timeout fires first -> one retry
        pll_lock = 1'b0;
        repeat (3) tick();
        base = obs_q.size(); abase = ack_total;
        do_start();
        wait_acks("t6b", abase + REG_N, 500);
        repeat (TMO) tick();
        pll_lock = 1'b1;
        wait_idle("t6b", 500);
        check_writes("t6b", base, 2);
        check_flags("t6b", 1'b1, 1'b0, 1);

        // 5: reset while a request is outstanding
        pll_lock = 1'b0;
        repeat (3) tick();
        resp_en = 1'b0;
        do_start();
        begin
            int n = 0;
            while (!spi_req && n < 200) begin
                tick();
                n++;
            end
        end
        chk("t5_req_up", {31'd0, spi_req}, 32'd1);
        rst_n = 1'b0;
        tick();
        chk("t5_req_drop", {31'd0, spi_req}, 32'd0);
        chk("t5_wdata",    {8'd0, spi_wdata}, 32'd0);
        chk("t5_addr",     {26'd0, rom_addr}, 32'd0);
        check_flags("t5", 1'b0, 1'b0, 0);
        rst_n   = 1'b1;
        resp_en = 1'b1;
        force_ack = 1'b1;
        tick();
        force_ack = 1'b0;
        sz = obs_q.size();
        repeat (40) tick();
        chk("t5_no_wr",   obs_q.size(), sz);
        chk("t5_idle_bs", {31'd0, cfg_busy}, 32'd0);
        chk("t5_idle_rq", {31'd0, spi_req}, 32'd0);
        ack_dly = $urandom_range(1, 6);
        base = obs_q.size(); abase = ack_total;
        do_start();
        wait_acks("t5r", abase + REG_N, 500);
        repeat (3) tick();
        pll_lock = 1'b1;
        wait_idle("t5r", 300);
        check_writes("t5r", base, 1);
        check_flags("t5r", 1'b1, 1'b0, 0);

        chk("wdata_stable", unstable, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
